riscv_core_dpath_vec_exec: RTL and testbench

Multi-cycle vector execute sequencer in the vector datapath. It accepts one vector operation with two 256-bit operands (8 × 32-bit elements) and a 3-bit vector length, and processes LANES_PER_CYCLE elements per cycle. It then issues a single write to the vector register file through `wen_p`/`waddr_p`/`wdata_p`. Operands come from the regfile read ports (`rdata0`/`rdata1`, `vl`) via the issue logic.

---
 rtl/riscv_core_dpath_vec_exec_if.sv | 27 ++
 rtl/riscv_core_dpath_vec_exec.sv | 138 +++++++++++++
 tb/tb_riscv_core_dpath_vec_exec.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_core_dpath_vec_exec_if.sv
// rtl/riscv_core_dpath_vec_exec_if.sv - request/writeback bundle for the vector execute sequencer
//   master: issue side (drives req_*, observes req_rdy and the write port)
//   slave : the sequencer (accepts req_*, drives req_rdy, wen_p/waddr_p/wdata_p, busy, illegal)
interface riscv_core_dpath_vec_exec_if;
    logic         req_val;
    logic         req_rdy;
    logic [2:0]   req_op;
    logic [4:0]   req_waddr;
    logic [255:0] req_src0;
    logic [255:0] req_src1;
    logic [2:0]   req_vl;
    logic         wen_p;
    logic [4:0]   waddr_p;
    logic [255:0] wdata_p;
    logic         busy;
    logic         illegal;

    modport master (
        output req_val, req_op, req_waddr, req_src0, req_src1, req_vl,
        input  req_rdy, wen_p, waddr_p, wdata_p, busy, illegal
    );

    modport slave (
        input  req_val, req_op, req_waddr, req_src0, req_src1, req_vl,
        output req_rdy, wen_p, waddr_p, wdata_p, busy, illegal
    );
endinterface

// File: rtl/riscv_core_dpath_vec_exec.sv
// rtl/riscv_core_dpath_vec_exec.sv - multi-cycle 8x32b vector execute sequencer with single regfile write
//   clk      : clock, all state on rising edge
//   reset_n  : asynchronous active-low reset
//   vif      : slave side of riscv_core_dpath_vec_exec_if (request in, regfile write out)
//   LANES_PER_CYCLE : elements computed per EXEC cycle (1, 2, 4 or 8)
//   RISCV_VEC_MUL_EN : when defined, op 111 multiplies; otherwise op 111 is illegal and writes zeros
module riscv_core_dpath_vec_exec #(
    parameter int LANES_PER_CYCLE = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    riscv_core_dpath_vec_exec_if.slave    vif
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    state_t         state;
    logic [2:0]     op_q;
    logic [4:0]     waddr_q;
    logic [255:0]   src0_q;
    logic [255:0]   src1_q;
    logic [255:0]   res_q;
    logic [255:0]   res_next;
    logic [3:0]     n_q;        // element count, 1..8
    logic [3:0]     idx_q;      // first element handled this EXEC cycle
    logic [4:0]     idx_adv;
    logic           last_exec;
    logic           op_illegal;

    logic           wen_q;
    logic [4:0]     waddr_p_q;
    logic [255:0]   wdata_p_q;
    logic           illegal_q;

    function automatic logic [31:0] elem_op(input logic [2:0] op,
                                            input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        case (op)
            3'b000:  r = a + b;
            3'b001:  r = a - b;
            3'b010:  r = a & b;
            3'b011:  r = a | b;
            3'b100:  r = a ^ b;
            3'b101:  r = a << b[4:0];
            3'b110:  r = a >> b[4:0];
`ifdef RISCV_VEC_MUL_EN
            default: r = a * b;
`else
            default: r = 32'h0;
`endif
        endcase
        return r;
    endfunction

`ifdef RISCV_VEC_MUL_EN
    assign op_illegal = 1'b0;
`else
    assign op_illegal = (op_q == 3'b111);
`endif

    assign idx_adv   = {1'b0, idx_q} + 5'(LANES_PER_CYCLE);
    assign last_exec = (idx_adv >= {1'b0, n_q});

    // Only lanes below n are written; the buffer was cleared on accept,
    // so tail elements leave as zero.
    always_comb begin
        logic [4:0] e;
        res_next = res_q;
        e        = '0;
        for (int j = 0; j < LANES_PER_CYCLE; j++) begin
            e = {1'b0, idx_q} + 5'(j);
            if (e < {1'b0, n_q}) begin
                res_next[32*e[2:0] +: 32] = elem_op(op_q,
                                                    src0_q[32*e[2:0] +: 32],
                                                    src1_q[32*e[2:0] +: 32]);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            op_q      <= '0;
            waddr_q   <= '0;
            src0_q    <= '0;
            src1_q    <= '0;
            res_q     <= '0;
            n_q       <= '0;
            idx_q     <= '0;
            wen_q     <= 1'b0;
            waddr_p_q <= '0;
            wdata_p_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            // Write-port outputs are pulses; they are zero unless the
            // final EXEC cycle loads them below.
            wen_q     <= 1'b0;
            waddr_p_q <= '0;
            wdata_p_q <= '0;
            illegal_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (vif.req_val) begin
                        op_q    <= vif.req_op;
                        waddr_q <= vif.req_waddr;
                        src0_q  <= vif.req_src0;
                        src1_q  <= vif.req_src1;
                        n_q     <= (vif.req_vl == 3'd0) ? 4'd8 : {1'b0, vif.req_vl};
                        idx_q   <= '0;
                        res_q   <= '0;
                        state   <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_q <= res_next;
                    idx_q <= idx_adv[3:0];
                    if (last_exec) begin
                        state     <= S_WB;
                        wen_q     <= 1'b1;
                        waddr_p_q <= waddr_q;
                        wdata_p_q <= res_next;
                        illegal_q <= op_illegal;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign vif.req_rdy = (state == S_IDLE);
    assign vif.busy    = (state != S_IDLE);
    assign vif.wen_p   = wen_q;
    assign vif.waddr_p = waddr_p_q;
    assign vif.wdata_p = wdata_p_q;
    assign vif.illegal = illegal_q;
endmodule

// File: tb/tb_riscv_core_dpath_vec_exec.sv
// tb/tb_riscv_core_dpath_vec_exec.sv - self-checking bench for riscv_core_dpath_vec_exec
module tb_riscv_core_dpath_vec_exec;
    localparam int L = 1;
`ifdef RISCV_VEC_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    int   tests = 0;
    int   failed = 0;

    riscv_core_dpath_vec_exec_if vif();

    riscv_core_dpath_vec_exec #(.LANES_PER_CYCLE(L)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .vif     (vif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  vl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        bit          ill;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int num_elems(input logic [2:0] vl);
        return (vl == 3'd0) ? 8 : int'(vl);
    endfunction

    // Reference: each element is plain modulo-2^32 arithmetic on the spec's rules.
    function automatic logic [255:0] model(input logic [2:0] op, input logic [2:0] vl,
                                           input logic [255:0] a, input logic [255:0] b);
        logic [255:0]    r;
        longint unsigned x;
        longint unsigned y;
        longint unsigned z;
        r = '0;
        for (int i = 0; i < num_elems(vl); i++) begin
            x = longint'(a[32*i +: 32]);
            y = longint'(b[32*i +: 32]);
            case (op)
                3'd0: z = x + y;
                3'd1: z = x - y;
                3'd2: z = x & y;
                3'd3: z = x | y;
                3'd4: z = x ^ y;
                3'd5: z = x << (y % 32);
                3'd6: z = x >> (y % 32);
                default: z = MUL_EN ? x * y : 64'd0;
            endcase
            r[32*i +: 32] = z[31:0];
        end
        return r;
    endfunction

    task automatic do_op(input string name, input logic [2:0] op, input logic [2:0] vl,
                         input logic [4:0] waddr, input logic [255:0] a, input logic [255:0] b,
                         input logic [255:0] exp_data, input bit exp_ill);
        int   cyc;
        int   busy_cnt;
        int   c;
        bit   got;
        bit   quiet_ok;
        logic [255:0] wd;
        logic [4:0]   wa;
        logic         il;
        c = (num_elems(vl) + L - 1) / L;
        @(negedge clk);
        chk({name, " rdy_before"}, 256'(vif.req_rdy), 256'(1));
        vif.req_op    = op;
        vif.req_vl    = vl;
        vif.req_waddr = waddr;
        vif.req_src0  = a;
        vif.req_src1  = b;
        vif.req_val   = 1'b1;
        @(posedge clk);
        #1;
        vif.req_val  = 1'b0;
        vif.req_src0 = ~a;
        vif.req_src1 = ~b;
        vif.req_op   = ~op;
        cyc = 0; busy_cnt = 0; got = 0; quiet_ok = 1;
        wd = '0; wa = '0; il = 1'b0;
        while (cyc < 40 && !got) begin
            @(negedge clk);
            cyc++;
            if (vif.busy) busy_cnt++;
            if (vif.wen_p) begin
                got = 1; wd = vif.wdata_p; wa = vif.waddr_p; il = vif.illegal;
            end else if (vif.wdata_p != 0 || vif.waddr_p != 0 || vif.illegal) begin
                quiet_ok = 0;
            end
        end
        chk({name, " latency"}, 256'(cyc), 256'(c + 1));
        chk({name, " wdata"}, wd, exp_data);
        chk({name, " waddr"}, 256'(wa), 256'(waddr));
        chk({name, " illegal"}, 256'(il), 256'(exp_ill));
        chk({name, " busy_cycles"}, 256'(busy_cnt), 256'(c + 1));
        chk({name, " quiet_outputs"}, 256'(quiet_ok), 256'(1));
        @(negedge clk);
        chk({name, " after_wb"}, {vif.wen_p, vif.req_rdy, vif.busy, vif.illegal, vif.wdata_p != 0},
            256'(5'b01000));
    endtask

    function automatic logic [255:0] bcast(input logic [31:0] v);
        return {8{v}};
    endfunction

    function automatic logic [255:0] exp_bcast(input logic [31:0] v, input logic [2:0] vl);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < num_elems(vl); i++) r[32*i +: 32] = v;
        return r;
    endfunction

    initial begin
        logic [255:0] ra;
        logic [255:0] rb;
        logic [2:0]   rop;
        logic [2:0]   rvl;
        int cyc;
        int wens;
        int w0;
        int w1;
        bit rdy_ok;

        tbl[0]  = '{3'd0, 3'd0, 32'h00000005, 32'h00000003, 32'h00000008, 1'b0};
        tbl[1]  = '{3'd1, 3'd3, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0};
        tbl[2]  = '{3'd5, 3'd0, 32'h00000001, 32'h00000024, 32'h00000010, 1'b0};
        tbl[3]  = '{3'd6, 3'd1, 32'h80000000, 32'h0000001F, 32'h00000001, 1'b0};
        tbl[4]  = '{3'd2, 3'd5, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0};
        tbl[5]  = '{3'd3, 3'd7, 32'hF0F0F0F0, 32'h0F0F0000, 32'hFFFFF0F0, 1'b0};
        tbl[6]  = '{3'd4, 3'd2, 32'hAAAAAAAA, 32'hFFFF0000, 32'h5555AAAA, 1'b0};
        tbl[7]  = '{3'd7, 3'd0, 32'h00010000, 32'h00010000, 32'h00000000, !MUL_EN};
        tbl[8]  = '{3'd7, 3'd4, 32'h00000003, 32'h00000007, MUL_EN ? 32'h00000015 : 32'h0, !MUL_EN};
        tbl[9]  = '{3'd0, 3'd1, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0};
        tbl[10] = '{3'd1, 3'd6, 32'h00000010, 32'h00000020, 32'hFFFFFFF0, 1'b0};

        reset_n = 1'b0;
        vif.req_val = 1'b0; vif.req_op = '0; vif.req_vl = '0; vif.req_waddr = '0;
        vif.req_src0 = '0; vif.req_src1 = '0;
        repeat (3) @(negedge clk);
        chk("reset_state", {vif.req_rdy, vif.busy, vif.wen_p, vif.illegal, vif.waddr_p != 0, vif.wdata_p != 0},
            256'(6'b100000));
        reset_n = 1'b1;

        foreach (tbl[i])
            do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].vl, 5'(i), bcast(tbl[i].a), bcast(tbl[i].b),
                  exp_bcast(tbl[i].e, tbl[i].vl), tbl[i].ill);

        // req_val held through EXEC/WB: exactly one write per operation.
        @(negedge clk);
        vif.req_op = 3'd0; vif.req_vl = 3'd2; vif.req_waddr = 5'd9;
        vif.req_src0 = bcast(32'd1); vif.req_src1 = bcast(32'd2);
        vif.req_val = 1'b1;
        @(posedge clk);
        cyc = 0; wens = 0; w0 = 0; w1 = 0; rdy_ok = 1;
        while (cyc < 40 && wens < 2) begin
            @(negedge clk);
            cyc++;
            if (vif.busy && vif.req_rdy) rdy_ok = 0;
            if (vif.wen_p) begin
                if (wens == 0) w0 = cyc; else w1 = cyc;
                wens++;
                if (wens == 2) vif.req_val = 1'b0;
            end
        end
        chk("hold_wen_count", 256'(wens), 256'(2));
        chk("hold_first_wen", 256'(w0), 256'(3));
        chk("hold_spacing", 256'(w1 - w0), 256'(4));
        chk("hold_rdy_low_busy", 256'(rdy_ok), 256'(1));
        repeat (6) begin
            @(negedge clk);
            if (vif.wen_p) wens++;
        end
        chk("hold_no_extra_wen", 256'(wens), 256'(2));

        // Reset in the third EXEC cycle aborts with no write.
        @(negedge clk);
        vif.req_op = 3'd0; vif.req_vl = 3'd0; vif.req_waddr = 5'd3;
        vif.req_src0 = bcast(32'd5); vif.req_src1 = bcast(32'd3);
        vif.req_val = 1'b1;
        @(posedge clk);
        #1 vif.req_val = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_immediate", {vif.req_rdy, vif.busy, vif.wen_p, vif.illegal, vif.wdata_p != 0},
            256'(5'b10000));
        wens = 0;
        repeat (2) begin
            @(negedge clk);
            if (vif.wen_p) wens++;
        end
        reset_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (vif.wen_p) wens++;
        end
        chk("abort_no_wen", 256'(wens), 256'(0));
        do_op("post_abort", tbl[0].op, tbl[0].vl, 5'd4, bcast(tbl[0].a), bcast(tbl[0].b),
              exp_bcast(tbl[0].e, tbl[0].vl), 1'b0);

        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < 8; i++) begin
                ra[32*i +: 32] = $urandom;
                rb[32*i +: 32] = $urandom;
            end
            rop = 3'($urandom_range(0, 7));
            rvl = 3'($urandom_range(0, 7));
            do_op($sformatf("rand%0d", k), rop, rvl, 5'($urandom), ra, rb,
                  model(rop, rvl, ra, rb), (rop == 3'd7) && !MUL_EN);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
